ov5640_pwr_seq: RTL and testbench

- Sequences OV5640 power-up (PWDN, RESET, settle) on sys_clk and releases the SCCB/config logic via power_done.
- Watches cfg_done with a timeout and retries the whole power cycle on failure.
- Accepts a runtime re-initialise request.
- Sits between system reset and the i2c_ctrl/ov5640_cfg pair. It replaces ad-hoc power counters with one supervised FSM.

---
 rtl/ov5640_pkg.sv | 45 ++++
 rtl/ov5640_pwr_seq_sync_2ff.sv | 21 ++
 rtl/ov5640_pwr_seq.sv | 128 ++++++++++++
 tb/tb_ov5640_pwr_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 power sequencer: state codes, 50 MHz
// default timings and the per-state camera pin decode.
package ov5640_pkg;

  localparam int SEQ_STATE_W = 3;

  localparam int T_PWDN_CYC_DEF   = 600_000;
  localparam int T_RST_CYC_DEF    = 200_000;
  localparam int T_SETTLE_CYC_DEF = 2_100_000;
  localparam int T_CFG_TO_CYC_DEF = 50_000_000;
  localparam int MAX_RETRY_DEF    = 3;
  localparam int CNT_W_DEF        = 26;

  typedef enum logic [SEQ_STATE_W-1:0] {
    S_PWDN   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_CFG    = 3'd3,
    S_RUN    = 3'd4,
    S_FAULT  = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic pwdn;
    logic rst_n;
    logic power_done;
    logic cam_ready;
  } cam_pins_t;

  // Sensor held powered down and in reset: used at reset, in S_PWDN and S_FAULT.
  localparam cam_pins_t PINS_OFF = '{pwdn: 1'b1, rst_n: 1'b0, power_done: 1'b0, cam_ready: 1'b0};

  function automatic cam_pins_t state_pins(seq_state_t s);
    cam_pins_t p;
    case (s)
      S_RST:    p = '{pwdn: 1'b0, rst_n: 1'b0, power_done: 1'b0, cam_ready: 1'b0};
      S_SETTLE: p = '{pwdn: 1'b0, rst_n: 1'b1, power_done: 1'b0, cam_ready: 1'b0};
      S_CFG:    p = '{pwdn: 1'b0, rst_n: 1'b1, power_done: 1'b1, cam_ready: 1'b0};
      S_RUN:    p = '{pwdn: 1'b0, rst_n: 1'b1, power_done: 1'b1, cam_ready: 1'b1};
      default:  p = PINS_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ov5640_pwr_seq_sync_2ff.sv
// Generic single-bit two-flop synchroniser, asynchronously reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ov5640_pwr_seq.sv
// Supervised OV5640 power-up sequencer: PWDN, RESET and settle timing, then
// waits for cfg_done with a timeout, retrying the whole power cycle on failure.
module ov5640_pwr_seq
  import ov5640_pkg::*;
#(
  parameter int T_PWDN_CYC   = T_PWDN_CYC_DEF,
  parameter int T_RST_CYC    = T_RST_CYC_DEF,
  parameter int T_SETTLE_CYC = T_SETTLE_CYC_DEF,
  parameter int T_CFG_TO_CYC = T_CFG_TO_CYC_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   cfg_done,
  input  logic                   reinit_req,
  output logic                   ov5640_pwdn,
  output logic                   ov5640_rst_n,
  output logic                   power_done,
  output logic                   cam_ready,
  output logic                   cfg_err,
  output logic [1:0]             retry_cnt,
  output logic [SEQ_STATE_W-1:0] seq_state
);

  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(T_PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CFG_LAST    = CNT_W'(T_CFG_TO_CYC - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic [1:0]       retry_next;
  logic             err_next;
  logic             timed;
  logic             cfg_done_s;
  logic             done_armed;
  cam_pins_t        pins_q;

  sync_2ff u_cfg_done_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (cfg_done),
    .q     (cfg_done_s)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_PWDN;
      timer     <= '0;
      retry_cnt <= 2'd0;
      cfg_err   <= 1'b0;
      pins_q    <= PINS_OFF;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      retry_cnt <= retry_next;
      cfg_err   <= err_next;
      pins_q    <= state_pins(state_next);
    end
  end

  always_comb begin
    state_next = state;
    retry_next = retry_cnt;
    err_next   = cfg_err;
    timed      = 1'b0;
    case (state)
      S_PWDN: begin
        timed = 1'b1;
        if (timer == PWDN_LAST) state_next = S_RST;
      end
      S_RST: begin
        timed = 1'b1;
        if (timer == RST_LAST) state_next = S_SETTLE;
      end
      S_SETTLE: begin
        timed = 1'b1;
        if (timer == SETTLE_LAST) state_next = S_CFG;
      end
      S_CFG: begin
        timed = 1'b1;
        // A completion arriving on the timeout cycle still counts as success.
        if (cfg_done_s && done_armed) begin
          state_next = S_RUN;
        end else if (timer == CFG_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_next = retry_cnt + 2'd1;
            state_next = S_PWDN;
          end else begin
            err_next   = 1'b1;
            state_next = S_FAULT;
          end
        end
      end
      S_RUN, S_FAULT: begin
        if (reinit_req) begin
          retry_next = 2'd0;
          err_next   = 1'b0;
          state_next = S_PWDN;
        end
      end
      default: state_next = S_PWDN;
    endcase
  end

  always_comb begin
    timer_next = timer;
    if (state_next != state) timer_next = '0;
    else if (timed)          timer_next = timer + CNT_W'(1);
  end

  // Held clear for all of S_PWDN so a cfg_done left high from the previous
  // run (or the synchroniser's reset value) cannot complete the next S_CFG.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                       done_armed <= 1'b0;
    else if (state == S_PWDN)             done_armed <= 1'b0;
    else if (!cfg_done_s && !power_done)  done_armed <= 1'b1;
  end

  assign ov5640_pwdn  = pins_q.pwdn;
  assign ov5640_rst_n = pins_q.rst_n;
  assign power_done   = pins_q.power_done;
  assign cam_ready    = pins_q.cam_ready;
  assign seq_state    = state;

endmodule

// File: tb/tb_ov5640_pwr_seq.sv
// Randomised scoreboard bench for ov5640_pwr_seq against a timeline-based
// reference model of the power sequence.
module tb_ov5640_pwr_seq;

  localparam int TP   = 6;
  localparam int TR   = 2;
  localparam int TS   = 21;
  localparam int TC   = 40;
  localparam int MAXR = 2;
  // Offsets from sequence start at which each phase begins.
  localparam int P1 = TP;
  localparam int P2 = TP + TR;
  localparam int P3 = TP + TR + TS;
  localparam int P4 = P3 + TC;
  localparam int W  = 10;

  localparam int M_SEQ   = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       cfg_done = 1'b0;
  logic       reinit_req = 1'b0;
  logic       ov5640_pwdn, ov5640_rst_n, power_done, cam_ready, cfg_err;
  logic [1:0] retry_cnt;
  logic [2:0] seq_state;

  always #5 sys_clk = ~sys_clk;

  ov5640_pwr_seq #(
    .T_PWDN_CYC   (TP),
    .T_RST_CYC    (TR),
    .T_SETTLE_CYC (TS),
    .T_CFG_TO_CYC (TC),
    .MAX_RETRY    (MAXR)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .cfg_done     (cfg_done),
    .reinit_req   (reinit_req),
    .ov5640_pwdn  (ov5640_pwdn),
    .ov5640_rst_n (ov5640_rst_n),
    .power_done   (power_done),
    .cam_ready    (cam_ready),
    .cfg_err      (cfg_err),
    .retry_cnt    (retry_cnt),
    .seq_state    (seq_state)
  );

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode plus elapsed cycles since the power sequence began.
  int m_mode, m_e, m_retry;
  bit m_err, m_armed, m_cd1, m_cd2;

  function automatic bit m_pd();
    return (m_mode == M_RUN) || (m_mode == M_SEQ && m_e >= P3);
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [2:0] st;
    logic pw, rn, pd, cr;
    if (m_mode == M_RUN)        st = 3'd4;
    else if (m_mode == M_FAULT) st = 3'd5;
    else if (m_e < P1)          st = 3'd0;
    else if (m_e < P2)          st = 3'd1;
    else if (m_e < P3)          st = 3'd2;
    else                        st = 3'd3;
    pw = (m_mode == M_FAULT) || (m_mode == M_SEQ && m_e < P1);
    rn = (m_mode == M_RUN) || (m_mode == M_SEQ && m_e >= P2);
    pd = m_pd();
    cr = (m_mode == M_RUN);
    return {st, 2'(m_retry), m_err, cr, pd, rn, pw};
  endfunction

  task automatic model_reset();
    m_mode = M_SEQ; m_e = 0; m_retry = 0;
    m_err = 0; m_armed = 0; m_cd1 = 0; m_cd2 = 0;
  endtask

  task automatic model_step(input logic cfg, input logic reinit);
    bit cds, arm_n;
    cds = m_cd2;
    if (m_mode == M_SEQ && m_e < P1) arm_n = 0;
    else if (!cds && !m_pd())        arm_n = 1;
    else                             arm_n = m_armed;
    if (m_mode == M_SEQ) begin
      if (m_e >= P3 && cds && m_armed) begin
        m_mode = M_RUN;
      end else if (m_e == P4 - 1) begin
        if (m_retry < MAXR) begin
          m_retry++;
          m_e = 0;
        end else begin
          m_err = 1;
          m_mode = M_FAULT;
        end
      end else begin
        m_e++;
      end
    end else if (reinit) begin
      m_mode = M_SEQ; m_e = 0; m_retry = 0; m_err = 0;
    end
    m_armed = arm_n;
    m_cd2 = m_cd1;
    m_cd1 = cfg;
  endtask

  // One clock cycle: drive inputs just after the edge, queue the expectation.
  task automatic cyc(input logic cfg, input logic reinit, input logic rst);
    cfg_done = cfg;
    reinit_req = reinit;
    sys_rst_n = rst;
    if (!rst) model_reset();
    exp_q.push_back(model_out());
    if (rst) model_step(cfg, reinit);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic seq_until_pd(input logic cfg);
    for (int i = 0; i < 300 && !m_pd(); i++) cyc(cfg, 1'b0, 1'b1);
  endtask

  // cfg_done low for elapsed in [drop, rise), high otherwise; reinit pulses at r1/r2.
  task automatic toggle_run(input int drop, input int rise, input int r1, input int r2);
    logic c, r;
    for (int i = 0; i < 400 && m_mode != M_RUN; i++) begin
      c = !(m_mode == M_SEQ && m_e >= drop && m_e < rise);
      r = (m_mode == M_SEQ) && (m_e == r1 || m_e == r2);
      cyc(c, r, 1'b1);
    end
  endtask

  always @(negedge sys_clk) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {seq_state, retry_cnt, cfg_err, cam_ready, power_done, ov5640_rst_n, ov5640_pwdn};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL outputs vec %0d t=%0t: got st=%0d retry=%0d err=%b cam=%b pd=%b rst_n=%b pwdn=%b, expected st=%0d retry=%0d err=%b cam=%b pd=%b rst_n=%b pwdn=%b",
                 vectors, $time, act_v[9:7], act_v[6:5], act_v[4], act_v[3], act_v[2], act_v[1], act_v[0],
                 exp_v[9:7], exp_v[6:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    logic cfg_r;
    int rise;
    model_reset();
    @(posedge sys_clk);
    #1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Nominal power-up, cfg_done raised 5 cycles after power_done.
    seq_until_pd(1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && m_mode != M_RUN; i++) cyc(1'b1, 1'b0, 1'b1);
    repeat ($urandom_range(2, 6)) cyc(1'b1, 1'b0, 1'b1);

    // Re-init from S_RUN, stale-high cfg_done must toggle before completing.
    cyc(1'b1, 1'b1, 1'b1);
    toggle_run($urandom_range(2, P3 - 4), P3 + $urandom_range(0, 10), -1, -1);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);

    // Re-init again; pulses in S_RST and S_CFG must be ignored.
    cyc(1'b1, 1'b1, 1'b1);
    rise = P3 + $urandom_range(5, 10);
    toggle_run($urandom_range(2, P3 - 4), rise, $urandom_range(P1, P2 - 1), P3 + $urandom_range(0, 3));
    repeat (3) cyc(1'b1, 1'b0, 1'b1);

    // cfg_done never asserts: three timeouts then fault.
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 400 && m_mode != M_FAULT; i++) cyc(1'b0, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);

    // Re-init from fault with cfg_done stuck high: same fault path.
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 400 && m_mode != M_FAULT; i++) cyc(1'b1, 1'b0, 1'b1);
    repeat (5) cyc(1'b1, 1'b0, 1'b1);

    // Re-init from fault, reset pulse at S_SETTLE timer=10, then complete.
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100 && !(m_mode == M_SEQ && m_e == P2 + 10); i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    seq_until_pd(1'b0);
    repeat ($urandom_range(0, 8)) cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30 && m_mode != M_RUN; i++) cyc(1'b1, 1'b0, 1'b1);

    // Random soak: sticky cfg_done toggles, sparse re-init and reset pulses.
    cfg_r = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) cfg_r = ~cfg_r;
      cyc(cfg_r, $urandom_range(0, 40) == 0, $urandom_range(0, 400) != 0);
    end

    @(negedge sys_clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
